bt_cmd_decoder: RTL and testbench

Receives ASCII track-navigation commands from the Bluetooth module's UART line and turns them into the 3-bit PREV/NEXT step strobes consumed by the song-select stage. It sits directly upstream of the song-select counter. It contains a UART 8N1 receiver, a two-byte command parser with an inter-byte timeout, and an optional acknowledge transmitter.

---
 rtl/bt_cmd_decoder_if.sv | 12 +
 rtl/bt_cmd_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_bt_cmd_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bt_cmd_decoder_if.sv
// rtl/bt_cmd_decoder_if.sv - Bluetooth UART command line and step-strobe bundle
// master is the decoder side; slave is the Bluetooth module / song-select side.
interface bt_cmd_decoder_if;
  logic       RXD;
  logic [2:0] PREV;
  logic [2:0] NEXT;
  logic       CMD_ERR;
  logic       TXD;

  modport master (input RXD, output PREV, output NEXT, output CMD_ERR, output TXD);
  modport slave  (output RXD, input PREV, input NEXT, input CMD_ERR, input TXD);
endinterface

// File: rtl/bt_cmd_decoder.sv
// rtl/bt_cmd_decoder.sv - UART 8N1 receiver and 'N'/'P' + digit command parser
// Defining BT_ACK_EN adds a transmitter that answers every emitted command with 'K'.
module bt_cmd_decoder #(
  parameter int CLK_HZ         = 100000000,
  parameter int BAUD           = 9600,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic CLK,
  input  logic RST,
  bt_cmd_decoder_if.master bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] CH_N  = 8'h4E;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_WAIT_DIGIT, P_EMIT} p_state_t;

  // [0] metastability, [1] synchronized, [2] previous; cleared so a start needs a fresh high-to-low
  logic [2:0] rxd_sync_q, rxd_sync_d;
  logic       rxd_s;
  logic       start_edge;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  p_state_t         p_state_q, p_state_d;
  logic             dir_next_q, dir_next_d;
  logic [2:0]       step_q, step_d;
  logic             pend_q, pend_d;
  logic             pend_next_q, pend_next_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             cmd_err_q, cmd_err_d;

  logic is_letter, is_eol, is_digit;

  always_comb begin
    rxd_sync_d = {rxd_sync_q[1:0], bus.RXD};
  end

  assign rxd_s      = rxd_sync_q[1];
  assign start_edge = rxd_sync_q[2] & ~rxd_sync_q[1];

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + CNT_W'(1);
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (start_edge) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rxd_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d     = '0;
          byte_valid_d = rxd_s;
          frame_err_d  = ~rxd_s;
          rx_state_d   = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  assign is_letter = (rx_shift_q == CH_N) || (rx_shift_q == CH_P);
  assign is_eol    = (rx_shift_q == CH_CR) || (rx_shift_q == CH_LF);
  assign is_digit  = (rx_shift_q >= 8'h31) && (rx_shift_q <= 8'h37);

  always_comb begin
    p_state_d   = p_state_q;
    dir_next_d  = dir_next_q;
    step_d      = step_q;
    pend_d      = pend_q;
    pend_next_d = pend_next_q;
    tmo_d       = tmo_q;
    cmd_err_d   = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (byte_valid_q) begin
          if (is_letter) begin
            dir_next_d = (rx_shift_q == CH_N);
            tmo_d      = TMO_LOAD;
            p_state_d  = P_WAIT_DIGIT;
          end else if (!is_eol) begin
            cmd_err_d = 1'b1;
          end
        end
      end
      P_WAIT_DIGIT: begin
        if (tmo_q != '0) tmo_d = tmo_q - TMO_W'(1);
        if (byte_valid_q) begin
          if (is_digit) begin
            step_d    = rx_shift_q[2:0];
            p_state_d = P_EMIT;
          end else if (is_letter) begin
            // the pending command goes out as a single step; the new letter waits behind it
            step_d      = 3'd1;
            pend_d      = 1'b1;
            pend_next_d = (rx_shift_q == CH_N);
            p_state_d   = P_EMIT;
          end else if (is_eol) begin
            step_d    = 3'd1;
            p_state_d = P_EMIT;
          end else begin
            cmd_err_d = 1'b1;
            p_state_d = P_IDLE;
          end
        end else if (tmo_q == '0) begin
          step_d    = 3'd1;
          p_state_d = P_EMIT;
        end
      end
      P_EMIT: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          dir_next_d = pend_next_q;
          tmo_d      = TMO_LOAD;
          p_state_d  = P_WAIT_DIGIT;
        end else begin
          p_state_d = P_IDLE;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rxd_sync_q   <= 3'b000;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      p_state_q    <= P_IDLE;
      dir_next_q   <= 1'b0;
      step_q       <= '0;
      pend_q       <= 1'b0;
      pend_next_q  <= 1'b0;
      tmo_q        <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      rxd_sync_q   <= rxd_sync_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      p_state_q    <= p_state_d;
      dir_next_q   <= dir_next_d;
      step_q       <= step_d;
      pend_q       <= pend_d;
      pend_next_q  <= pend_next_d;
      tmo_q        <= tmo_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  assign bus.NEXT    = (p_state_q == P_EMIT &&  dir_next_q) ? step_q : 3'd0;
  assign bus.PREV    = (p_state_q == P_EMIT && !dir_next_q) ? step_q : 3'd0;
  assign bus.CMD_ERR = cmd_err_q | frame_err_q;

`ifdef BT_ACK_EN
  logic             tx_busy_q, tx_busy_d;
  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;

  // an EMIT during a transmission is dropped, never queued
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    if (!tx_busy_q) begin
      if (p_state_q == P_EMIT) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, 8'h4B, 1'b0};
        tx_bit_d   = '0;
        tx_cnt_d   = '0;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign bus.TXD = tx_busy_q ? tx_shift_q[0] : 1'b1;
`else
  assign bus.TXD = 1'b1;
`endif

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb/tb_bt_cmd_decoder.sv - directed bench for bt_cmd_decoder at 10 clocks per bit
module tb_bt_cmd_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int next_n, prev_n, err_n, overlap_n, txd_low_n;
  int next_val, prev_val, next_cyc, prev_cyc, err_first_cyc, err_last_cyc;

  bt_cmd_decoder_if bus();

  bt_cmd_decoder #(
    .CLK_HZ(1000000),
    .BAUD(100000),
    .TIMEOUT_CYCLES(500)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.NEXT !== 3'd0) begin next_n++; next_val = int'(bus.NEXT); next_cyc = cyc; end
      if (bus.PREV !== 3'd0) begin prev_n++; prev_val = int'(bus.PREV); prev_cyc = cyc; end
      if (bus.NEXT !== 3'd0 && bus.PREV !== 3'd0) overlap_n++;
      if (bus.CMD_ERR === 1'b1) begin
        if (err_n == 0) err_first_cyc = cyc;
        err_n++;
        err_last_cyc = cyc;
      end
      if (bus.TXD !== 1'b1) txd_low_n++;
    end
  end

  task automatic clear_mon();
    next_n = 0; prev_n = 0; err_n = 0; overlap_n = 0;
    next_val = 0; prev_val = 0; next_cyc = 0; prev_cyc = 0;
    err_first_cyc = 0; err_last_cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t0);
    @(posedge CLK); #1;
    t0 = cyc;
    bus.RXD = 1'b0;
    repeat (10) @(posedge CLK); #1;
    for (int i = 0; i < 8; i++) begin
      bus.RXD = b[i];
      repeat (10) @(posedge CLK); #1;
    end
    bus.RXD = stop_bit;
    repeat (10) @(posedge CLK); #1;
    bus.RXD = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(5);
    @(negedge CLK);
    checks++; if (bus.NEXT !== 3'd0) begin errors++; $display("FAIL reset_next: got %0d want 0", bus.NEXT); end
    checks++; if (bus.PREV !== 3'd0) begin errors++; $display("FAIL reset_prev: got %0d want 0", bus.PREV); end
    checks++; if (bus.CMD_ERR !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", bus.CMD_ERR); end
    checks++; if (bus.TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", bus.TXD); end
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(10);
    clear_mon();
  endtask

  task automatic test_next3();
    int t;
    clear_mon();
    send_byte(8'h4E, 1'b1, t);
    send_byte(8'h33, 1'b1, t);
    idle(20);
    checks++; if (next_n != 1) begin errors++; $display("FAIL n3_next_count: got %0d want 1", next_n); end
    checks++; if (next_val != 3) begin errors++; $display("FAIL n3_next_value: got %0d want 3", next_val); end
    checks++; if (next_cyc != t + 99) begin errors++; $display("FAIL n3_next_time: got %0d want %0d", next_cyc, t + 99); end
    checks++; if (prev_n != 0) begin errors++; $display("FAIL n3_prev_quiet: got %0d want 0", prev_n); end
    checks++; if (err_n != 0) begin errors++; $display("FAIL n3_no_err: got %0d want 0", err_n); end
  endtask

  task automatic test_timeout();
    int t;
    clear_mon();
    send_byte(8'h50, 1'b1, t);
    idle(600);
    checks++; if (prev_n != 1) begin errors++; $display("FAIL tmo_prev_count: got %0d want 1", prev_n); end
    checks++; if (prev_val != 1) begin errors++; $display("FAIL tmo_prev_value: got %0d want 1", prev_val); end
    checks++; if (prev_cyc != t + 600) begin errors++; $display("FAIL tmo_prev_time: got %0d want %0d", prev_cyc, t + 600); end
    checks++; if (err_n != 0 || next_n != 0) begin errors++; $display("FAIL tmo_quiet: got err=%0d next=%0d want 0 0", err_n, next_n); end
  endtask

  task automatic test_back_to_back();
    int t, tp, t5;
    clear_mon();
    send_byte(8'h4E, 1'b1, t);
    send_byte(8'h50, 1'b1, tp);
    send_byte(8'h35, 1'b1, t5);
    idle(20);
    checks++; if (next_n != 1 || next_val != 1) begin errors++; $display("FAIL b2b_next: got n=%0d v=%0d want 1 1", next_n, next_val); end
    checks++; if (next_cyc != tp + 99) begin errors++; $display("FAIL b2b_next_time: got %0d want %0d", next_cyc, tp + 99); end
    checks++; if (prev_n != 1 || prev_val != 5) begin errors++; $display("FAIL b2b_prev: got n=%0d v=%0d want 1 5", prev_n, prev_val); end
    checks++; if (prev_cyc != t5 + 99) begin errors++; $display("FAIL b2b_prev_time: got %0d want %0d", prev_cyc, t5 + 99); end
    checks++; if (overlap_n != 0 || err_n != 0) begin errors++; $display("FAIL b2b_clean: got overlap=%0d err=%0d want 0 0", overlap_n, err_n); end
  endtask

  task automatic test_errors();
    int t, t9, tb;
    clear_mon();
    send_byte(8'h4E, 1'b1, t);
    send_byte(8'h39, 1'b1, t9);
    send_byte(8'h58, 1'b1, t);
    send_byte(8'h4E, 1'b0, tb);
    idle(600);
    checks++; if (err_n != 3) begin errors++; $display("FAIL err_count: got %0d want 3", err_n); end
    checks++; if (err_first_cyc != t9 + 99) begin errors++; $display("FAIL err_first_time: got %0d want %0d", err_first_cyc, t9 + 99); end
    checks++; if (err_last_cyc != tb + 98) begin errors++; $display("FAIL err_frame_time: got %0d want %0d", err_last_cyc, tb + 98); end
    checks++; if (next_n != 0 || prev_n != 0) begin errors++; $display("FAIL err_no_strobe: got next=%0d prev=%0d want 0 0", next_n, prev_n); end
    clear_mon();
    send_byte(8'h4E, 1'b1, t);
    send_byte(8'h32, 1'b1, t);
    idle(20);
    checks++; if (next_n != 1 || next_val != 2 || err_n != 0) begin errors++; $display("FAIL err_then_idle: got next=%0d v=%0d err=%0d want 1 2 0", next_n, next_val, err_n); end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_mon();
    fork
      send_byte(8'h4E, 1'b1, t);
      begin
        idle(35);
        RST = 1'b1;
        @(negedge CLK);
        checks++; if (bus.NEXT !== 3'd0 || bus.PREV !== 3'd0) begin errors++; $display("FAIL rmid_strobes: got next=%0d prev=%0d want 0 0", bus.NEXT, bus.PREV); end
        checks++; if (bus.CMD_ERR !== 1'b0 || bus.TXD !== 1'b1) begin errors++; $display("FAIL rmid_err_txd: got err=%b txd=%b want 0 1", bus.CMD_ERR, bus.TXD); end
      end
    join
    idle(2);
    RST = 1'b0;
    idle(10);
    clear_mon();
    send_byte(8'h50, 1'b1, t);
    send_byte(8'h32, 1'b1, t);
    idle(20);
    checks++; if (prev_n != 1 || prev_val != 2) begin errors++; $display("FAIL rmid_prev: got n=%0d v=%0d want 1 2", prev_n, prev_val); end
    checks++; if (next_n != 0 || err_n != 0) begin errors++; $display("FAIL rmid_quiet: got next=%0d err=%0d want 0 0", next_n, err_n); end
  endtask

  task automatic test_ack();
`ifdef BT_ACK_EN
    int t, target;
    logic [9:0] frame;
    frame = {1'b1, 8'h4B, 1'b0};
    idle(150);
    clear_mon();
    send_byte(8'h4E, 1'b1, t);
    send_byte(8'h31, 1'b1, t);
    for (int i = 0; i < 10; i++) begin
      target = t + 105 + 10 * i;
      while (cyc < target) @(negedge CLK);
      checks++; if (bus.TXD !== frame[i]) begin errors++; $display("FAIL ack_bit%0d: got %b want %b", i, bus.TXD, frame[i]); end
    end
    idle(20);
    checks++; if (bus.TXD !== 1'b1) begin errors++; $display("FAIL ack_idle: got %b want 1", bus.TXD); end
`else
    checks++; if (txd_low_n != 0) begin errors++; $display("FAIL txd_tied_high: got %0d low cycles want 0", txd_low_n); end
`endif
  endtask

  initial begin
    bus.RXD = 1'b1;
    txd_low_n = 0;
    clear_mon();
    test_reset();
    test_next3();
    test_timeout();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    test_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
